rr_arbiter4: RTL and testbench

- Four-requester round-robin arbiter with a grant-hold handshake and a hold timeout.
- Shares one downstream resource (e.g. an encoder/datapath slot) between four clients.
- Sits between the requesters and the shared unit. Drives a one-hot grant plus the encoded winner index (2-bit, same encoding as the 4-to-2 encoder family).
- Rotating priority guarantees no requester starves.

---
 rtl/arb_pkg.sv | 18 +
 rtl/rr_select4.sv | 36 +++
 rtl/rr_arbiter4.sv | 118 +++++++++++
 tb/tb_rr_arbiter4.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared types and constants for the four-way round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

   localparam int N_REQ = 4;
   localparam int ID_W  = 2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_select4.sv
`default_nettype none
// ============================================================================
// Module   : rr_select4
// Brief    : Combinational rotating-priority pick: first set req bit at or
//            above ptr, wrapping 3->0.
// Revision : 1.0 - initial release
// ============================================================================
module rr_select4
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic             any,
   output logic [ID_W-1:0]  winner
);

   logic [2*N_REQ-1:0] w_dbl;
   logic [N_REQ-1:0]   w_rot;
   logic [ID_W-1:0]    w_low;

   always_comb begin
      w_dbl = {req, req};
      // Rotating right by ptr puts the highest-priority client at bit 0.
      w_rot = w_dbl[ptr +: N_REQ];
      w_low = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_low = ID_W'(k);
         end
      end
      winner = w_low + ptr;
      any    = |req;
   end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter4
// Brief    : Four-requester round-robin arbiter with grant hold and forced
//            release after MAX_HOLD cycles when others are waiting.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter4
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id,
   output logic             grant_valid,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);

   state_t            r_state;
   logic [ID_W-1:0]   r_ptr;
   logic [CNT_W-1:0]  r_hold_cnt;
   logic [N_REQ-1:0]  r_grant;
   logic [ID_W-1:0]   r_grant_id;
   logic              r_grant_valid;
   logic              r_timeout;

   state_t            w_state;
   logic [ID_W-1:0]   w_ptr;
   logic [CNT_W-1:0]  w_hold_cnt;
   logic [N_REQ-1:0]  w_grant;
   logic [ID_W-1:0]   w_grant_id;
   logic              w_grant_valid;
   logic              w_timeout;
   logic              w_any;
   logic [ID_W-1:0]   w_winner;
   logic              w_owner_req;
   logic              w_others;

   rr_select4 u_select (
      .req    (req),
      .ptr    (r_ptr),
      .any    (w_any),
      .winner (w_winner)
   );

   always_comb begin
      w_state       = r_state;
      w_ptr         = r_ptr;
      w_hold_cnt    = r_hold_cnt;
      w_grant       = r_grant;
      w_grant_id    = r_grant_id;
      w_grant_valid = r_grant_valid;
      w_timeout     = 1'b0;
      w_owner_req   = req[r_grant_id];
      w_others      = (req & ~r_grant) != '0;

      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state       = BUSY;
               w_grant       = N_REQ'(1) << w_winner;
               w_grant_id    = w_winner;
               w_grant_valid = 1'b1;
               w_hold_cnt    = '0;
            end
         end
         BUSY: begin
            // Normal release is tested first so it always beats a timeout.
            if (!w_owner_req || (r_hold_cnt == c_hold_last && w_others)) begin
               w_state       = IDLE;
               w_grant       = '0;
               w_grant_id    = '0;
               w_grant_valid = 1'b0;
               w_ptr         = r_grant_id + ID_W'(1);
               w_timeout     = w_owner_req;
            end else if (r_hold_cnt != c_hold_last) begin
               w_hold_cnt = r_hold_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_ptr         <= '0;
         r_hold_cnt    <= '0;
         r_grant       <= '0;
         r_grant_id    <= '0;
         r_grant_valid <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         r_state       <= w_state;
         r_ptr         <= w_ptr;
         r_hold_cnt    <= w_hold_cnt;
         r_grant       <= w_grant;
         r_grant_id    <= w_grant_id;
         r_grant_valid <= w_grant_valid;
         r_timeout     <= w_timeout;
      end
   end

   assign grant       = r_grant;
   assign grant_id    = r_grant_id;
   assign grant_valid = r_grant_valid;
   assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter4
// Brief    : Scoreboard bench for rr_arbiter4 against a client-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter4;

   localparam int MAX_HOLD = 8;
   localparam int WAIT_MAX = 3 * (MAX_HOLD + 1);

   typedef struct packed {
      logic [3:0] grant;
      logic [1:0] id;
      logic       valid;
      logic       tmo;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] grant_id;
   logic       grant_valid;
   logic       timeout;

   exp_t       exp_q[$];
   int         n_checks;
   int         n_pass;

   // Model state: owning client (-1 when idle), rotation start, cycles held.
   int         m_owner;
   int         m_ptr;
   int         m_held;
   int         waits[4];

   rr_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .grant       (grant),
      .grant_id    (grant_id),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int want);
      n_checks++;
      if (act == want) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
   endtask

   // Advances the model across one clock edge seeing request vector r.
   task automatic model_edge(input logic [3:0] r);
      exp_t e;
      bit   tmo;
      bit   others;
      tmo = 0;
      if (m_owner < 0) begin
         for (int i = 0; i < 4; i++) begin
            if (m_owner < 0 && r[(m_ptr + i) % 4]) m_owner = (m_ptr + i) % 4;
         end
         m_held = (m_owner >= 0) ? 1 : 0;
      end else begin
         others = 0;
         for (int i = 0; i < 4; i++) if (i != m_owner && r[i]) others = 1;
         if (!r[m_owner] || (m_held >= MAX_HOLD && others)) begin
            tmo     = r[m_owner];
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
            m_held  = 0;
         end else begin
            m_held++;
         end
      end
      e.grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      e.id    = (m_owner >= 0) ? 2'(m_owner) : 2'b00;
      e.valid = (m_owner >= 0);
      e.tmo   = tmo;
      exp_q.push_back(e);
   endtask

   task automatic apply(input logic [3:0] r);
      req = r;
      model_edge(r);
   endtask

   task automatic step(input logic [3:0] r);
      @(negedge clk);
      apply(r);
   endtask

   // Monitor: pops one expected result per edge and checks invariants.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            check("onehot0", int'($onehot0(grant)), 1);
            check("valid_eq_or", int'(grant_valid), int'(|grant));
            if (grant_valid) check("id_enc", int'(grant[grant_id]), 1);
            for (int i = 0; i < 4; i++) begin
               if (req[i] && !grant[i]) waits[i]++;
               else waits[i] = 0;
               if (waits[i] > WAIT_MAX) check("starve", waits[i], WAIT_MAX);
            end
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("grant", int'(grant), int'(e.grant));
               check("grant_id", int'(grant_id), int'(e.id));
               check("grant_valid", int'(grant_valid), int'(e.valid));
               check("timeout", int'(timeout), int'(e.tmo));
            end
         end else begin
            for (int i = 0; i < 4; i++) waits[i] = 0;
         end
      end
   end

   initial begin
      logic [3:0] r;
      n_checks = 0;
      n_pass   = 0;
      for (int i = 0; i < 4; i++) waits[i] = 0;
      model_reset();
      req = 4'b0000;
      rst = 1'b1;
      #1;
      check("rst_grant", int'(grant), 0);
      check("rst_id", int'(grant_id), 0);
      check("rst_valid", int'(grant_valid), 0);
      check("rst_timeout", int'(timeout), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      apply(4'b0000);

      // Single grant to client 0, then release moves ptr to 1.
      step(4'b0001);
      step(4'b0000);
      step(4'b0000);

      // Clients 1,3,0 contend; each drops its request after two grant cycles.
      for (int c = 0; c < 16; c++) begin
         r = 4'b1011;
         if (m_owner >= 0 && m_held >= 2) r[m_owner] = 1'b0;
         step(r);
      end
      step(4'b0000);
      step(4'b0000);

      // Client 2 holds while client 0 waits: forced release after MAX_HOLD.
      step(4'b0100);
      repeat (14) step(4'b0101);
      step(4'b0000);
      step(4'b0000);

      // Sole requester 3 is never forced off.
      repeat (20) step(4'b1000);
      step(4'b0000);
      step(4'b0000);

      // Asynchronous reset mid-grant, then full contention starts at client 0.
      repeat (4) step(4'b1111);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async_grant", int'(grant), 0);
      check("async_id", int'(grant_id), 0);
      check("async_valid", int'(grant_valid), 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      apply(4'b1111);
      repeat (3) step(4'b1111);
      step(4'b0000);
      step(4'b0000);

      // Random traffic with sticky requests so long holds and timeouts occur.
      r = 4'b0000;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 99) < 15) r[i] = ~r[i];
         end
         step(r);
      end
      step(4'b0000);
      @(posedge clk);
      #2;
      check("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
